// File: rtl/controlador_cruzamento.sv
// Two-way intersection sequencer: A/B light phases, all-red clearance,
// pedestrian walk phase with a latched request that can cut a green short,
// and run-time programmable phase durations.
module controlador_cruzamento #(
  parameter logic [7:0] T_VERDE_A    = 8'd2,
  parameter logic [7:0] T_VERDE_B    = 8'd2,
  parameter logic [7:0] T_AMARELO    = 8'd1,
  parameter logic [7:0] T_TODOS_VERM = 8'd1,
  parameter logic [7:0] T_PEDESTRE   = 8'd3,
  parameter logic [7:0] T_VERDE_MIN  = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       P,
  output logic       pedido
);

  typedef enum logic [2:0] {
    A_VERDE   = 3'd0,
    A_AMARELO = 3'd1,
    TV1       = 3'd2,
    B_VERDE   = 3'd3,
    B_AMARELO = 3'd4,
    TV2       = 3'd5,
    PEDESTRE  = 3'd6
  } estado_t;

  typedef struct packed {
    logic [7:0] verde_a;
    logic [7:0] verde_b;
    logic [7:0] amarelo;
    logic [7:0] todos_verm;
    logic [7:0] pedestre;
    logic [7:0] verde_min;
  } duracoes_t;

  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;

  estado_t   estado, prox;
  duracoes_t dur;
  logic [7:0] cnt;
  logic [7:0] dec;
  logic       prox_b;

  logic       corte;
  logic       sai;
  logic [7:0] cnt_carga;
  logic [7:0] vmin;
  logic [8:0] dec_p1;

  // Counter preload for a duration; a zero duration behaves as one cycle.
  function automatic logic [7:0] carga(input logic [7:0] d);
    return (d == 8'd0) ? 8'd0 : d - 8'd1;
  endfunction

  // Duration register that governs a given state.
  function automatic logic [7:0] dur_de(input estado_t e, input duracoes_t d);
    logic [7:0] r;
    r = d.verde_a;
    case (e)
      A_VERDE:   r = d.verde_a;
      B_VERDE:   r = d.verde_b;
      A_AMARELO,
      B_AMARELO: r = d.amarelo;
      TV1, TV2:  r = d.todos_verm;
      PEDESTRE:  r = d.pedestre;
      default:   r = d.verde_a;
    endcase
    return r;
  endfunction

  // Exit decision: counter expiry, or a pedestrian cut once minimum green is served.
  always_comb begin
    vmin   = (dur.verde_min == 8'd0) ? 8'd1 : dur.verde_min;
    dec_p1 = {1'b0, dec} + 9'd1;
    corte  = (estado == A_VERDE || estado == B_VERDE) && pedido &&
             (dec_p1 >= {1'b0, vmin});
    sai    = (cnt == 8'd0) || corte;
  end

  // Next-state selection; the new state's counter load uses the pre-write registers.
  always_comb begin
    prox = estado;
    if (sai) begin
      case (estado)
        A_VERDE:   prox = A_AMARELO;
        A_AMARELO: prox = TV1;
        TV1:       prox = pedido ? PEDESTRE : B_VERDE;
        B_VERDE:   prox = B_AMARELO;
        B_AMARELO: prox = TV2;
        TV2:       prox = pedido ? PEDESTRE : A_VERDE;
        PEDESTRE:  prox = prox_b ? B_VERDE : A_VERDE;
        default:   prox = A_VERDE;
      endcase
    end
    cnt_carga = carga(dur_de(prox, dur));
  end

  // Light decode straight from the state register.
  always_comb begin
    A = LUZ_VERMELHO;
    B = LUZ_VERMELHO;
    P = 1'b0;
    case (estado)
      A_VERDE:   A = LUZ_VERDE;
      A_AMARELO: A = LUZ_AMARELO;
      B_VERDE:   B = LUZ_VERDE;
      B_AMARELO: B = LUZ_AMARELO;
      PEDESTRE:  P = 1'b1;
      default:   ;
    endcase
  end

  // State register with per-phase down-counter and elapsed counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= A_VERDE;
      cnt    <= carga(T_VERDE_A);
      dec    <= 8'd0;
    end else if (sai) begin
      estado <= prox;
      cnt    <= cnt_carga;
      dec    <= 8'd0;
    end else begin
      cnt <= cnt - 8'd1;
      if (dec != 8'hFF) dec <= dec + 8'd1;
    end
  end

  // Pedestrian request latch and the green to resume after the walk phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pedido <= 1'b0;
      prox_b <= 1'b0;
    end else begin
      if (sai && prox == PEDESTRE) begin
        pedido <= 1'b0;
        prox_b <= (estado == TV1);
      end else if (bt && estado != PEDESTRE) begin
        pedido <= 1'b1;
      end
    end
  end

  // Duration registers; writes take effect from the next entry to the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur <= '{verde_a:    T_VERDE_A,
               verde_b:    T_VERDE_B,
               amarelo:    T_AMARELO,
               todos_verm: T_TODOS_VERM,
               pedestre:   T_PEDESTRE,
               verde_min:  T_VERDE_MIN};
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    dur.verde_a    <= cfg_data;
        3'd1:    dur.verde_b    <= cfg_data;
        3'd2:    dur.amarelo    <= cfg_data;
        3'd3:    dur.todos_verm <= cfg_data;
        3'd4:    dur.pedestre   <= cfg_data;
        3'd5:    dur.verde_min  <= cfg_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_cruzamento.sv
// Scoreboard bench for controlador_cruzamento: the driver steps a phase-level
// reference model and queues expected outputs; a monitor compares them.
module tb_controlador_cruzamento;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bt = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [7:0] cfg_data = 8'd0;
  logic [2:0] A, B;
  logic       P, pedido;

  controlador_cruzamento dut (
    .clk(clk), .rst(rst), .bt(bt), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .A(A), .B(B), .P(P), .pedido(pedido)
  );

  always #5 clk = ~clk;

  logic [7:0] fila[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase index in the cycle, time spent in it, latched duration.
  // 0 A green, 1 A yellow, 2 all-red 1, 3 B green, 4 B yellow, 5 all-red 2, 6 walk
  int fase, t, dur_at;
  int dur[6];
  bit ped, volta_b;

  function automatic int pelo_menos1(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int dur_de(input int f);
    case (f)
      0:       return pelo_menos1(dur[0]);
      3:       return pelo_menos1(dur[1]);
      1, 4:    return pelo_menos1(dur[2]);
      2, 5:    return pelo_menos1(dur[3]);
      default: return pelo_menos1(dur[4]);
    endcase
  endfunction

  function automatic logic [7:0] saida_modelo();
    logic [2:0] a, b;
    a = (fase == 0) ? 3'b001 : (fase == 1) ? 3'b010 : 3'b100;
    b = (fase == 3) ? 3'b001 : (fase == 4) ? 3'b010 : 3'b100;
    return {a, b, (fase == 6), ped};
  endfunction

  task automatic modelo_reset();
    dur = '{2, 2, 1, 1, 3, 1};
    fase = 0; t = 0; dur_at = 2; ped = 0; volta_b = 0;
  endtask

  task automatic modelo_passo(input bit b, input bit we, input int ad, input int dt);
    bit cut, fim;
    int nf;
    cut = (fase == 0 || fase == 3) && ped && (t + 1 >= pelo_menos1(dur[5]));
    fim = (t + 1 >= dur_at) || cut;
    nf = fase;
    if (fim) begin
      case (fase)
        0: nf = 1;
        1: nf = 2;
        2: nf = ped ? 6 : 3;
        3: nf = 4;
        4: nf = 5;
        5: nf = ped ? 6 : 0;
        default: nf = volta_b ? 3 : 0;
      endcase
    end
    if (fim && nf == 6) begin
      ped = 0;
      volta_b = (fase == 2);
    end else if (b && fase != 6) begin
      ped = 1;
    end
    if (fim) begin
      fase = nf; t = 0; dur_at = dur_de(nf);
    end else begin
      t++;
    end
    if (we && ad < 6) dur[ad] = dt;
  endtask

  // Fixed default-timing table for edge k after reset (no request, no writes).
  function automatic logic [7:0] tabela(input int k);
    logic [2:0] a, b;
    int m;
    m = k % 8;
    a = (m <= 1) ? 3'b001 : (m == 2) ? 3'b010 : 3'b100;
    b = (m == 4 || m == 5) ? 3'b001 : (m == 6) ? 3'b010 : 3'b100;
    return {a, b, 1'b0, 1'b0};
  endfunction

  // One clock: called at a falling edge, drives inputs, queues the expectation.
  task automatic ciclo(input bit b, input bit we, input int ad, input int dt,
                       input int tab_k);
    bt = b; cfg_we = we; cfg_addr = 3'(ad); cfg_data = 8'(dt);
    @(posedge clk);
    modelo_passo(b, we, ad, dt);
    fila.push_back((tab_k >= 0) ? tabela(tab_k) : saida_modelo());
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle; checked immediately and across one held edge.
  task automatic reset_dut();
    #1;
    rst = 1'b1;
    modelo_reset();
    fila.push_back(saida_modelo());
    bt = 0; cfg_we = 0;
    @(posedge clk);
    fila.push_back(saida_modelo());
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ocioso(input int n);
    for (int i = 0; i < n; i++) ciclo(0, 0, 0, 0, -1);
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    logic [7:0] e;
    logic [7:0] g;
    forever begin
      @(posedge clk or posedge rst);
      #2;
      if (fila.size() > 0) begin
        e = fila.pop_front();
        g = {A, B, P, pedido};
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL saida t=%0t got A=%b B=%b P=%b pedido=%b exp A=%b B=%b P=%b pedido=%b",
                   $time, g[7:5], g[4:2], g[1], g[0], e[7:5], e[4:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got no finish, exp finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // Default timing, fixed table
    reset_dut();
    for (int k = 1; k <= 20; k++) ciclo(0, 0, 0, 0, k);

    // Request at edge 1 leads to walk after the first all-red
    reset_dut();
    ciclo(1, 0, 0, 0, -1);
    ocioso(14);

    // verde_a=10 written during A green: applies from next A green
    reset_dut();
    ciclo(0, 1, 0, 10, -1);
    ocioso(24);

    // verde_a=10, verde_min=3, request at edge 9 cuts green at edge 11
    reset_dut();
    ciclo(0, 1, 0, 10, -1);
    ciclo(0, 0, 0, 0, -1);
    ciclo(0, 1, 5, 3, -1);
    ocioso(5);
    ciclo(1, 0, 0, 0, -1);
    ocioso(12);

    // Button held through walk phase
    reset_dut();
    for (int i = 0; i < 30; i++) ciclo(1, 0, 0, 0, -1);
    ocioso(4);

    // Reset during B green with a pending request
    reset_dut();
    ocioso(3);
    ciclo(1, 0, 0, 0, -1);
    reset_dut();
    for (int k = 1; k <= 10; k++) ciclo(0, 0, 0, 0, k);

    // Zero durations and writes to ignored addresses
    reset_dut();
    ciclo(0, 1, 2, 0, -1);
    ciclo(0, 1, 3, 0, -1);
    ciclo(0, 1, 6, 0, -1);
    ciclo(0, 1, 7, 0, -1);
    ciclo(0, 1, 4, 0, -1);
    ocioso(6);
    ciclo(1, 0, 0, 0, -1);
    ocioso(10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) reset_dut();
      else ciclo($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12))
                                             : int'($urandom_range(0, 4)), -1);
    end

    @(posedge clk);
    #3;
    n_cmp++;
    if (fila.size() != 0) begin
      n_err++;
      $display("FAIL fila_vazia got %0d pending, exp 0", fila.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
